// File: rtl/mask_gen_pkg.sv
// -----------------------------------------------------------------------------
// mask_gen_pkg
// Definitions shared by the mask generator and its row serializer:
//   - mrs_state_t : row serializer FSM states (IDLE, SHIFT, LATCH)
//   - CHUNK_W_DEF : default number of mask bits per sensor transfer
//   - MAX_SENSOR_W_DEF / MAX_SENSOR_H_DEF : default sensor geometry limits
//   - mask_type_t : mask-type encodings used by the generator
//   - ceil_div / clamp helpers used when sampling the row geometry
// No ports (package).
// -----------------------------------------------------------------------------
package mask_gen_pkg;

  localparam int CHUNK_W_DEF      = 32;
  localparam int MAX_SENSOR_W_DEF = 1920;
  localparam int MAX_SENSOR_H_DEF = 1080;

  // Row serializer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } mrs_state_t;

  // Mask-type encodings produced by the generator.
  typedef enum logic [2:0] {
    MASK_NONE    = 3'd0,
    MASK_ROI     = 3'd1,
    MASK_STRIPE  = 3'd2,
    MASK_CHECKER = 3'd3,
    MASK_RANDOM  = 3'd4,
    MASK_CUSTOM  = 3'd5
  } mask_type_t;

  // Integer ceiling division; b must be positive.
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Clamp a value into [lo, hi].
  function automatic int clamp_int(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/mask_chunk_select.sv
// -----------------------------------------------------------------------------
// mask_chunk_select
// Combinational mux that picks chunk number `idx` out of a row buffer.
// Bit 0 of the buffer is pixel 0; bit 0 of the chunk is the lowest pixel of
// that chunk. An index beyond the last chunk yields all zeros.
// Ports:
//   row   in  [0:WIDTH-1]    row buffer
//   idx   in  [IDX_W-1:0]    chunk index
//   chunk out [0:CHUNK_W-1]  selected chunk
// -----------------------------------------------------------------------------
module mask_chunk_select
  import mask_gen_pkg::*;
#(
  parameter int WIDTH   = MAX_SENSOR_W_DEF,
  parameter int CHUNK_W = CHUNK_W_DEF,
  parameter int IDX_W   = 6
) (
  input  logic [0:WIDTH-1]   row,
  input  logic [IDX_W-1:0]   idx,
  output logic [0:CHUNK_W-1] chunk
);

  localparam int NCH = WIDTH / CHUNK_W;

  always_comb begin
    chunk = '0;
    for (int c = 0; c < NCH; c++) begin
      if (idx == IDX_W'(c)) begin
        chunk = row[c*CHUNK_W +: CHUNK_W];
      end
    end
  end

endmodule

// File: rtl/mask_row_serializer.sv
// -----------------------------------------------------------------------------
// mask_row_serializer
// Captures a full row mask from the mask generator and streams it to the image
// sensor's mask shift chain in CHUNK_W-bit chunks, then strobes row_latch.
// Rows are counted up to the frame height; frame_done marks the last row.
//
// Optional feature macro: MASK_ROW_SER_PARITY_EN
//   defined   -> adds output sensor_parity (registered even parity of
//                sensor_data, held together with sensor_data)
//   undefined -> port and logic absent
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   clk_en         in   clock enable; low freezes all state and outputs
//   image_sensor_w in   [10:0] active row width in pixels
//   image_sensor_h in   [10:0] active rows per frame
//   mg_mask        in   [0:max_image_sensor_w-1] row mask, bit 0 = pixel 0
//   rp_valid       in   mg_mask valid
//   mask_ready     out  high in IDLE; row accepted on rp_valid && mask_ready
//   sensor_data    out  [0:CHUNK_W-1] current chunk
//   sensor_parity  out  even parity of sensor_data (macro only)
//   sensor_valid   out  chunk valid
//   sensor_ready   in   sensor accepts chunk on sensor_valid && sensor_ready
//   row_latch      out  one-cycle strobe after the last chunk of a row
//   frame_done     out  one-cycle strobe with row_latch of the last row
//   row_idx        out  [10:0] row being sent or next to be sent
// -----------------------------------------------------------------------------
module mask_row_serializer
  import mask_gen_pkg::*;
#(
  parameter int max_image_sensor_w = MAX_SENSOR_W_DEF,
  parameter int max_image_sensor_h = MAX_SENSOR_H_DEF,
  parameter int CHUNK_W            = CHUNK_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clk_en,
  input  logic [10:0]                   image_sensor_w,
  input  logic [10:0]                   image_sensor_h,
  input  logic [0:max_image_sensor_w-1] mg_mask,
  input  logic                          rp_valid,
  output logic                          mask_ready,
  output logic [0:CHUNK_W-1]            sensor_data,
`ifdef MASK_ROW_SER_PARITY_EN
  output logic                          sensor_parity,
`endif
  output logic                          sensor_valid,
  input  logic                          sensor_ready,
  output logic                          row_latch,
  output logic                          frame_done,
  output logic [10:0]                   row_idx
);

  localparam int NCH = max_image_sensor_w / CHUNK_W;
  localparam int KW  = $clog2(NCH + 1);

  mrs_state_t state_q, state_d;

  logic [0:max_image_sensor_w-1] buf_q, buf_d;
  logic [0:max_image_sensor_w-1] masked_row;
  logic [KW-1:0]                 k_q, k_d;
  logic [KW-1:0]                 n_q, n_d;
  logic [10:0]                   h_q, h_d;
  logic [10:0]                   row_q, row_d;
  logic [0:CHUNK_W-1]            chunk_d;
  logic                          last_row;

  int w_eff;
  int n_eff;
  int h_eff;

  // Row geometry as it would be sampled by an accept this cycle.
  always_comb begin
    w_eff = clamp_int(int'(image_sensor_w), 0, max_image_sensor_w);
    n_eff = clamp_int(ceil_div(w_eff, CHUNK_W), 1, NCH);
    h_eff = clamp_int(int'(image_sensor_h), 1, max_image_sensor_h);
  end

  // Pixels beyond the active width are zeroed on capture so a partial final
  // chunk is padded with zeros.
  always_comb begin
    masked_row = '0;
    for (int i = 0; i < max_image_sensor_w; i++) begin
      masked_row[i] = mg_mask[i] && (i < w_eff);
    end
  end

  assign last_row = (row_q == (h_q - 11'd1));

  // Next-state logic. The data path registers load from the *_d values so
  // sensor_data is registered yet already shows chunk 0 the cycle after accept.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    k_d     = k_q;
    n_d     = n_q;
    h_d     = h_q;
    row_d   = row_q;
    unique case (state_q)
      IDLE: begin
        if (rp_valid) begin
          buf_d   = masked_row;
          n_d     = KW'(n_eff);
          k_d     = '0;
          state_d = SHIFT;
          // The frame height is only taken at the first row of a frame.
          if (row_q == 11'd0) begin
            h_d = 11'(h_eff);
          end
        end
      end
      SHIFT: begin
        if (sensor_ready) begin
          if (k_q == (n_q - KW'(1))) begin
            state_d = LATCH;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      LATCH: begin
        state_d = IDLE;
        row_d   = last_row ? 11'd0 : (row_q + 11'd1);
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  mask_chunk_select #(
    .WIDTH   (max_image_sensor_w),
    .CHUNK_W (CHUNK_W),
    .IDX_W   (KW)
  ) u_chunk_select (
    .row   (buf_d),
    .idx   (k_d),
    .chunk (chunk_d)
  );

  // State and data registers; reset wins over clk_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      k_q         <= '0;
      n_q         <= KW'(1);
      h_q         <= 11'd1;
      row_q       <= 11'd0;
      sensor_data <= '0;
    end else if (clk_en) begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      k_q         <= k_d;
      n_q         <= n_d;
      h_q         <= h_d;
      row_q       <= row_d;
      sensor_data <= (state_d == SHIFT) ? chunk_d : '0;
    end
  end

`ifdef MASK_ROW_SER_PARITY_EN
  // Parity is registered alongside sensor_data so both hold together.
  always_ff @(posedge clk) begin
    if (rst) begin
      sensor_parity <= 1'b0;
    end else if (clk_en) begin
      sensor_parity <= (state_d == SHIFT) ? (^chunk_d) : 1'b0;
    end
  end
`else
  // No parity output in this build.
`endif

  assign mask_ready   = (state_q == IDLE);
  assign sensor_valid = (state_q == SHIFT);
  assign row_latch    = (state_q == LATCH);
  assign frame_done   = (state_q == LATCH) && last_row;
  assign row_idx      = row_q;

endmodule
